// File: rtl/serial_tx_fifo.sv
// Buffered asynchronous serial transmitter: valid/ready write port into a small FIFO,
// frames sent LSB first with optional parity, 1 or 2 stop bits, zero gap between frames.
module serial_tx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          block,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(CLK_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0]  CTR_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW1-1:0] FULL_CNT  = AW1'(FIFO_DEPTH);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam logic           PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        ctr, ctr_nxt;
    logic [BW-1:0]        bit_ctr, bit_ctr_nxt;
    logic                 stop_ctr, stop_ctr_nxt;
    logic                 tx_nxt;
    logic                 pop;
    logic                 wr_en;
    logic                 ctr_wrap;
    logic                 can_start;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW1-1:0]       count;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    assign wr_ready  = (count != FULL_CNT);
    assign wr_en     = wr_valid && wr_ready;
    assign level     = count;
    assign busy      = (state != S_IDLE) || (count != '0);
    assign ctr_wrap  = (ctr == CTR_LAST);
    assign can_start = !block && (count != '0);

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Shift register and parity are loaded on the pop that enters START
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
        end else if (state == S_DATA && ctr_wrap) begin
            shreg   <= shreg >> 1;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr_wrap ? '0 : ctr + 1'b1;
        bit_ctr_nxt  = bit_ctr;
        stop_ctr_nxt = stop_ctr;
        pop          = 1'b0;
        tx_nxt       = 1'b1;
        case (state)
            S_IDLE: begin
                ctr_nxt = '0;
                if (can_start) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (ctr_wrap) begin
                    bit_ctr_nxt = '0;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                tx_nxt = shreg[0];
                if (ctr_wrap) begin
                    bit_ctr_nxt = bit_ctr + 1'b1;
                    if (bit_ctr == BIT_LAST) begin
                        stop_ctr_nxt = 1'b0;
                        state_nxt    = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                tx_nxt = par_bit;
                if (ctr_wrap) begin
                    stop_ctr_nxt = 1'b0;
                    state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (ctr_wrap) begin
                    stop_ctr_nxt = 1'b1;
                    // End of frame: chain straight into the next start bit when allowed
                    if (stop_ctr == STOP_LAST) begin
                        if (can_start) begin
                            pop       = 1'b1;
                            state_nxt = S_START;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                ctr_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // tx is registered from the current state, so the line lags the state by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ctr      <= '0;
            bit_ctr  <= '0;
            stop_ctr <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            ctr      <= ctr_nxt;
            bit_ctr  <= bit_ctr_nxt;
            stop_ctr <= stop_ctr_nxt;
            tx       <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: 8N1 instance with a frame-decoding scoreboard, plus
// 7-bit odd/even parity, 2-stop-bit instances checked against per-cycle tables.
module tb_serial_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       block;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [2:0] level;
    logic       busy;
    logic       tx;

    logic       p_block;
    logic       p_valid;
    logic [6:0] p_data;
    logic       o_ready, e_ready;
    logic [2:0] o_level, e_level;
    logic       o_busy, e_busy;
    logic       o_tx, e_tx;

    always #5 clk = ~clk;

    serial_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .block(block), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .level(level), .busy(busy), .tx(tx));

    serial_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_odd (
        .clk(clk), .rst_n(rst_n), .block(p_block), .wr_valid(p_valid), .wr_data(p_data),
        .wr_ready(o_ready), .level(o_level), .busy(o_busy), .tx(o_tx));

    serial_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_even (
        .clk(clk), .rst_n(rst_n), .block(p_block), .wr_valid(p_valid), .wr_data(p_data),
        .wr_ready(e_ready), .level(e_level), .busy(e_busy), .tx(e_tx));

    typedef struct {
        logic [7:0] d;
        logic [9:0] bits;
    } sf_vec_t;

    typedef struct {
        logic [6:0]  d;
        logic [10:0] odd_bits;
        logic [10:0] even_bits;
    } par_vec_t;

    sf_vec_t    sf_tab[4];
    par_vec_t   par_tab[4];
    logic [7:0] bb_words[6];
    logic [7:0] exp_q[$];

    int checks   = 0;
    int failures = 0;
    int frames_rx = 0;
    int gaps[64];
    int errs;
    int n;
    int f0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", wr_ready, 1'b1);
        @(posedge clk);
        if (k < 200) exp_q.push_back(d);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_rx < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", frames_rx, target);
    endtask

    // Frame decoder: samples mid-bit, records idle gap before each start bit
    initial begin
        int         mon_cnt = 0;
        int         idle_cnt = 0;
        bit         mon_act = 1'b0;
        logic       prev_tx = 1'b1;
        logic [7:0] rx_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_act  = 1'b0;
                mon_cnt  = 0;
                idle_cnt = 0;
                prev_tx  = 1'b1;
            end else begin
                if (!mon_act) begin
                    if (prev_tx && !tx) begin
                        mon_act = 1'b1;
                        mon_cnt = 0;
                        if (frames_rx < 64) gaps[frames_rx] = idle_cnt;
                        idle_cnt = 0;
                    end else begin
                        idle_cnt++;
                    end
                end else begin
                    mon_cnt++;
                    if (mon_cnt == 2) begin
                        check("mon_start_bit", tx, 1'b0);
                    end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
                        rx_word = {tx, rx_word[7:1]};
                    end else if (mon_cnt == 38) begin
                        check("mon_stop_bit", tx, 1'b1);
                        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                        else check("sb_word", rx_word, exp_q.pop_front());
                        frames_rx++;
                    end
                    if (mon_cnt == 39) mon_act = 1'b0;
                end
                prev_tx = tx;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sf_tab[0] = '{8'hA5, 10'b1101001010};
        sf_tab[1] = '{8'h3C, 10'b1001111000};
        sf_tab[2] = '{8'h01, 10'b1000000010};
        sf_tab[3] = '{8'h80, 10'b1100000000};
        par_tab[0] = '{7'h03, 11'b11100000110, 11'b11000000110};
        par_tab[1] = '{7'h55, 11'b11110101010, 11'b11010101010};
        par_tab[2] = '{7'h7F, 11'b11011111110, 11'b11111111110};
        par_tab[3] = '{7'h40, 11'b11010000000, 11'b11110000000};
        bb_words = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81, 8'h7E};

        rst_n = 1'b1; block = 1'b0; wr_valid = 1'b0; wr_data = '0;
        p_block = 1'b0; p_valid = 1'b0; p_data = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_par_tx", o_tx, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single frames: every cycle of the line against the table
        foreach (sf_tab[i]) begin
            push(sf_tab[i].d);
            @(negedge clk);
            check("sf_level_after_write", level, 3'd1);
            check("sf_tx_idle_n", tx, 1'b1);
            @(negedge clk);
            check("sf_level_after_pop", level, 3'd0);
            check("sf_tx_idle_n1", tx, 1'b1);
            errs = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (tx !== sf_tab[i].bits[c/4]) errs++;
                if (c == 38) check("sf_busy_last", busy, 1'b1);
                if (c == 39) check("sf_busy_drop", busy, 1'b0);
            end
            check("sf_frame_bits", errs, 0);
            @(negedge clk);
            check("sf_tx_after", tx, 1'b1);
        end

        // Back-to-back writes on consecutive cycles up to full, then one held write
        f0 = frames_rx;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = bb_words[i];
            n = 0;
            while (!wr_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (i < 5) check("bb_no_stall", n, 0);
            else check("bb_held_cycles", n, 37);
            @(posedge clk);
            exp_q.push_back(bb_words[i]);
            #1;
            if (i == 4) begin
                check("bb_level_full", level, 3'd4);
                check("bb_ready_low", wr_ready, 1'b0);
            end
            if (i == 5) check("bb_level_refill", level, 3'd4);
        end
        wr_valid = 1'b0;
        wait_frames(f0 + 6, 400);
        for (int k = 1; k < 6; k++) check("bb_gap", gaps[f0 + k], 0);

        // block asserted mid-frame holds the second frame until release
        f0 = frames_rx;
        push(8'hC3);
        push(8'h3A);
        repeat (10) @(negedge clk);
        block = 1'b1;
        wait_frames(f0 + 1, 100);
        repeat (3) @(negedge clk);
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || level !== 3'd1) errs++;
        end
        check("blk_hold", errs, 0);
        check("blk_busy", busy, 1'b1);
        block = 1'b0;
        @(negedge clk);
        check("blk_no_early_start", tx, 1'b1);
        check("blk_popped", level, 3'd0);
        @(negedge clk);
        check("blk_start", tx, 1'b0);
        wait_frames(f0 + 2, 100);

        // Reset during DATA with two words queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("rst_mid_level", level, 3'd2);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_level0", level, 3'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", wr_ready, 1'b1);
        exp_q.delete();
        f0 = frames_rx;
        @(negedge clk);
        #2 rst_n = 1'b1;
        errs = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("rst_quiet", errs, 0);
        check("rst_no_frames", frames_rx, f0);

        // Write on the same cycle as the pop
        f0 = frames_rx;
        block = 1'b1;
        push(8'h96);
        @(negedge clk);
        check("swp_level_pre", level, 3'd1);
        check("swp_tx_pre", tx, 1'b1);
        block    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h69;
        @(posedge clk);
        exp_q.push_back(8'h69);
        #1 wr_valid = 1'b0;
        check("swp_level", level, 3'd1);
        wait_frames(f0 + 2, 150);

        // Parity instances: 7 data bits, 2 stop bits, 44-cycle frames
        foreach (par_tab[i]) begin
            @(negedge clk);
            p_valid = 1'b1;
            p_data  = par_tab[i].d;
            @(posedge clk);
            #1 p_valid = 1'b0;
            @(negedge clk);
            check("par_tx_idle_n", o_tx, 1'b1);
            @(negedge clk);
            check("par_tx_idle_n1", e_tx, 1'b1);
            errs = 0;
            for (int c = 0; c < 44; c++) begin
                @(negedge clk);
                if (o_tx !== par_tab[i].odd_bits[c/4]) errs++;
                if (e_tx !== par_tab[i].even_bits[c/4]) errs++;
                if (c == 42) check("par_busy_last", o_busy, 1'b1);
                if (c == 43) check("par_busy_drop", e_busy, 1'b0);
            end
            check("par_frame_bits", errs, 0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
